// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// controller state encoding and iteration-counter sizing.
package mult_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_FIX  = S_FIX
    } state_t;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// Datapath of the shift-add multiplier: magnitude registers, accumulator
// and iteration counter, advanced one partial product per step.
module shift_add_core
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcnd_load,
    input  logic [WIDTH-1:0]     mpr_load,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 mpr_zero,
    output logic                 count_last
);

    localparam int CW = count_width(WIDTH);

    logic [WIDTH-1:0]   mpr_r;
    logic [2*WIDTH-1:0] mcnd_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      count_r;

    // Operand load and one add/shift iteration per step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mpr_r   <= '0;
            mcnd_r  <= '0;
            acc_r   <= '0;
            count_r <= '0;
        end else if (load) begin
            mpr_r   <= mpr_load;
            mcnd_r  <= {{WIDTH{1'b0}}, mcnd_load};
            acc_r   <= '0;
            count_r <= '0;
        end else if (step) begin
            if (mpr_r[0]) begin
                acc_r <= acc_r + mcnd_r;
            end
            mpr_r   <= mpr_r >> 1;
            mcnd_r  <= mcnd_r << 1;
            count_r <= count_r + CW'(1);
        end
    end

    // Both flags look ahead to the state after the current step completes.
    assign acc        = acc_r;
    assign mpr_zero   = (mpr_r[WIDTH-1:1] == '0);
    assign count_last = (count_r == CW'(WIDTH - 1));

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier with start/busy/done handshake,
// early termination on the multiplier magnitude and registered results.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 sign,
    output logic                 zflag
);

    localparam int PW = 2 * WIDTH;

    // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1'b1)) : x;
    endfunction

    state_t           state_r;
    logic             neg_r;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic             neg_s;
    logic             load_s;
    logic             step_s;
    logic [PW-1:0]    acc_s;
    logic             mpr_zero_s;
    logic             count_last_s;

    // Operand conditioning and datapath control decode.
    always_comb begin
        mag_a_s = magnitude(multiplicand, signed_mode);
        mag_b_s = magnitude(multiplier, signed_mode);
        neg_s   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        load_s  = (state_r == ST_IDLE) && start;
        step_s  = (state_r == ST_RUN);
    end

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load_s),
        .step       (step_s),
        .mcnd_load  (mag_a_s),
        .mpr_load   (mag_b_s),
        .acc        (acc_s),
        .mpr_zero   (mpr_zero_s),
        .count_last (count_last_s)
    );

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            neg_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            sign    <= 1'b0;
            zflag   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        neg_r   <= neg_s;
                        busy    <= 1'b1;
                        state_r <= (mag_b_s == '0) ? ST_FIX : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mpr_zero_s || count_last_s) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // A zero product is reported as non-negative even when neg_r is set.
                    result  <= neg_r ? (~acc_s + PW'(1'b1)) : acc_s;
                    zflag   <= (acc_s == '0);
                    sign    <= neg_r & (acc_s != '0);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
